prop_delay_meter_mc: RTL and testbench

Multi-channel, cycle-accurate propagation-delay meter: the synthesizable, parametrised successor to the single-pair input-capacitance measurement submodule. For each of `N_CH` channels it timestamps the input-threshold crossing event and the output-threshold crossing event, then averages `2**AVG_LOG2` delay samples. The averaged results are streamed out over a valid/ready port. It sits between the comparator event outputs of the capacitance test bench and the result logger, and honours the same `fin_test` abort.

---
 rtl/prop_delay_meter_mc.sv | 243 ++++++++++++++++++++++++
 tb/tb_prop_delay_meter_mc.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prop_delay_meter_mc.sv
// Multi-channel in->out propagation-delay meter: averages 2**AVG_LOG2 samples per channel and
// streams results over valid/ready. Define PDM_SYNC_EN to add 2-flop input synchronisers.
module prop_delay_meter_mc #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 65535
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             fin_test,
  input  logic [N_CH-1:0]  in_evt,
  input  logic [N_CH-1:0]  out_evt,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_ch,
  output logic [CNT_W-1:0] res_time,
  output logic             res_tmo,
  output logic             done
);
  localparam int unsigned AccW   = CNT_W + AVG_LOG2;
  localparam int unsigned NSampW = AVG_LOG2 + 1;
  localparam logic [NSampW-1:0] NSamp = NSampW'(2 ** AVG_LOG2);

  typedef enum logic [1:0] {StIdle, StMeasure, StDrain, StFinish} st_e;
  typedef enum logic [1:0] {ChWaitIn, ChCount, ChDone} ch_st_e;

  logic [N_CH-1:0] in_s, out_s;
`ifdef PDM_SYNC_EN
  logic [N_CH-1:0] in_m1_q, in_m2_q, out_m1_q, out_m2_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_m1_q  <= '0;
      in_m2_q  <= '0;
      out_m1_q <= '0;
      out_m2_q <= '0;
    end else begin
      in_m1_q  <= in_evt;
      in_m2_q  <= in_m1_q;
      out_m1_q <= out_evt;
      out_m2_q <= out_m1_q;
    end
  end
  assign in_s  = in_m2_q;
  assign out_s = out_m2_q;
`else
  assign in_s  = in_evt;
  assign out_s = out_evt;
`endif

  // Registered edge detect: an edge is acted on one cycle after it reaches in_s/out_s.
  logic [N_CH-1:0] in_d1_q, in_d2_q, out_d1_q, out_d2_q, in_rise, out_rise;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_d1_q  <= '0;
      in_d2_q  <= '0;
      out_d1_q <= '0;
      out_d2_q <= '0;
    end else begin
      in_d1_q  <= in_s;
      in_d2_q  <= in_d1_q;
      out_d1_q <= out_s;
      out_d2_q <= out_d1_q;
    end
  end
  assign in_rise  = in_d1_q & ~in_d2_q;
  assign out_rise = out_d1_q & ~out_d2_q;

  st_e               st_q, st_d;
  logic [31:0]       tmo_q, tmo_d, tmo_inc;
  logic              tmo_hit, all_done, load, ch_run, ch_clr, sel_done;
  logic [AccW-1:0]   sel_acc;
  logic              res_valid_q, res_valid_d, res_tmo_q, res_tmo_d;
  logic [3:0]        res_ch_q, res_ch_d;
  logic [CNT_W-1:0]  res_time_q, res_time_d;

  ch_st_e            ch_st_q [N_CH];
  ch_st_e            ch_st_d [N_CH];
  logic [CNT_W-1:0]  cnt_q   [N_CH];
  logic [CNT_W-1:0]  cnt_d   [N_CH];
  logic [AccW-1:0]   acc_q   [N_CH];
  logic [AccW-1:0]   acc_d   [N_CH];
  logic [NSampW-1:0] nsamp_q [N_CH];
  logic [NSampW-1:0] nsamp_d [N_CH];

  always_comb begin
    st_d        = st_q;
    tmo_d       = tmo_q;
    res_valid_d = res_valid_q;
    res_ch_d    = res_ch_q;
    res_time_d  = res_time_q;
    res_tmo_d   = res_tmo_q;
    load        = 1'b0;
    ch_run      = 1'b0;
    ch_clr      = 1'b0;
    all_done    = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (ch_st_q[i] != ChDone) all_done = 1'b0;
    end
    tmo_inc = (tmo_q == '1) ? tmo_q : tmo_q + 32'd1;
    tmo_hit = (tmo_inc >= TIMEOUT);

    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d   = StMeasure;
          tmo_d  = '0;
          ch_clr = 1'b1;
        end
      end
      StMeasure: begin
        tmo_d = tmo_inc;
        if (all_done || tmo_hit) begin
          st_d        = StDrain;
          res_valid_d = 1'b1;
          res_ch_d    = 4'd0;
          load        = 1'b1;
        end else begin
          ch_run = 1'b1;
        end
      end
      StDrain: begin
        if (res_ready) begin
          if (res_ch_q == 4'(N_CH - 1)) begin
            st_d        = StFinish;
            res_valid_d = 1'b0;
          end else begin
            res_ch_d = res_ch_q + 4'd1;
            load     = 1'b1;
          end
        end
      end
      StFinish: st_d = StIdle;
      default:  st_d = StIdle;
    endcase

    // Channels are frozen once MEASURE ends, so anything not in ChDone here timed out.
    sel_done = 1'b0;
    sel_acc  = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (res_ch_d == 4'(i)) begin
        sel_done = (ch_st_q[i] == ChDone);
        sel_acc  = acc_q[i];
      end
    end
    if (load) begin
      res_tmo_d  = !sel_done;
      res_time_d = sel_done ? CNT_W'(sel_acc >> AVG_LOG2) : '1;
    end

    if (fin_test) begin
      st_d        = StIdle;
      res_valid_d = 1'b0;
      ch_run      = 1'b0;
      ch_clr      = 1'b0;
    end
  end

  always_comb begin
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] sample;
    logic             take;
    for (int i = 0; i < N_CH; i++) begin
      ch_st_d[i] = ch_st_q[i];
      cnt_d[i]   = cnt_q[i];
      acc_d[i]   = acc_q[i];
      nsamp_d[i] = nsamp_q[i];
      cnt_inc    = (cnt_q[i] == '1) ? cnt_q[i] : cnt_q[i] + CNT_W'(1);
      sample     = '0;
      take       = 1'b0;
      if (ch_clr) begin
        ch_st_d[i] = ChWaitIn;
        cnt_d[i]   = '0;
        acc_d[i]   = '0;
        nsamp_d[i] = '0;
      end else if (ch_run) begin
        unique case (ch_st_q[i])
          ChWaitIn: begin
            if (in_rise[i]) begin
              cnt_d[i]   = '0;
              ch_st_d[i] = ChCount;
              take       = out_rise[i];
            end
          end
          ChCount: begin
            cnt_d[i] = cnt_inc;
            if (out_rise[i]) begin
              take   = 1'b1;
              sample = cnt_inc;
            end
          end
          ChDone: ;
          default: ;
        endcase
        if (take) begin
          acc_d[i]   = acc_q[i] + AccW'(sample);
          nsamp_d[i] = nsamp_q[i] + NSampW'(1);
          ch_st_d[i] = (nsamp_q[i] + NSampW'(1) == NSamp) ? ChDone : ChWaitIn;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= StIdle;
      tmo_q       <= '0;
      res_valid_q <= 1'b0;
      res_ch_q    <= '0;
      res_time_q  <= '0;
      res_tmo_q   <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        ch_st_q[i] <= ChWaitIn;
        cnt_q[i]   <= '0;
        acc_q[i]   <= '0;
        nsamp_q[i] <= '0;
      end
    end else begin
      st_q        <= st_d;
      tmo_q       <= tmo_d;
      res_valid_q <= res_valid_d;
      res_ch_q    <= res_ch_d;
      res_time_q  <= res_time_d;
      res_tmo_q   <= res_tmo_d;
      for (int i = 0; i < N_CH; i++) begin
        ch_st_q[i] <= ch_st_d[i];
        cnt_q[i]   <= cnt_d[i];
        acc_q[i]   <= acc_d[i];
        nsamp_q[i] <= nsamp_d[i];
      end
    end
  end

  assign busy      = (st_q != StIdle);
  assign done      = (st_q == StFinish);
  assign res_valid = res_valid_q;
  assign res_ch    = res_ch_q;
  assign res_time  = res_time_q;
  assign res_tmo   = res_tmo_q;

endmodule

// File: tb/tb_prop_delay_meter_mc.sv
// Self-checking bench for prop_delay_meter_mc: directed and random vector table checked
// against a cycle-scan reference model, plus fin_test and async-reset sequences.
module tb_prop_delay_meter_mc;
  localparam int unsigned NCh  = 4;
  localparam int unsigned CntW = 16;
  localparam int unsigned Tmo  = 200;
  localparam int          NV   = 8;

  logic            clk = 1'b0;
  logic            rst_n, start, fin_test, res_ready;
  logic [NCh-1:0]  in_evt, out_evt;
  logic            busy, res_valid, res_tmo, done;
  logic [3:0]      res_ch;
  logic [CntW-1:0] res_time;

  always #5 clk = ~clk;

  prop_delay_meter_mc #(
    .N_CH(NCh), .CNT_W(CntW), .AVG_LOG2(2), .TIMEOUT(Tmo)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .fin_test(fin_test),
    .in_evt(in_evt), .out_evt(out_evt), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_ch(res_ch), .res_time(res_time), .res_tmo(res_tmo),
    .done(done)
  );

  typedef struct {
    logic [NCh-1:0][3:0][7:0]  dly;       // in->out distance of each of the 4 pairs
    logic [NCh-1:0]            no_out;    // channel never sees out_evt
    logic [NCh-1:0][3:0]       hold;      // cycles res_ready stays low per result
    logic [NCh-1:0][CntW-1:0]  exp_time;
    logic [NCh-1:0]            exp_tmo;
  } vec_t;

  vec_t           vecs [NV];
  logic [NCh-1:0] in_sch  [256];
  logic [NCh-1:0] out_sch [256];
  int             nvec = 0;
  int             nerr = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One-cycle pulses; channel c starts at cycle 2+c, pairs separated by a 3-cycle gap.
  task automatic build(input vec_t v);
    for (int k = 0; k < 256; k++) begin
      in_sch[k]  = '0;
      out_sch[k] = '0;
    end
    for (int c = 0; c < NCh; c++) begin
      int t;
      t = 2 + c;
      for (int p = 0; p < 4; p++) begin
        in_sch[t][c] = 1'b1;
        if (!v.no_out[c]) out_sch[t + int'(v.dly[c][p])][c] = 1'b1;
        t += int'(v.dly[c][p]) + 3;
      end
    end
  endtask

  // Reference: walk the port schedule; an edge in cycle k takes effect at edge k+2 after
  // start, and channels stop updating at the timeout edge.
  task automatic model(output logic [NCh-1:0][CntW-1:0] et, output logic [NCh-1:0] etmo,
                       output int drain);
    int last;
    bit alldone;
    last    = 0;
    alldone = 1'b1;
    for (int c = 0; c < NCh; c++) begin
      int tin, sum, n, fin;
      tin = -1; sum = 0; n = 0; fin = -1;
      for (int k = 0; k <= int'(Tmo) - 3 && fin < 0; k++) begin
        if (tin < 0) begin
          if (in_sch[k][c]) begin
            if (out_sch[k][c]) n++;
            else tin = k;
          end
        end else if (out_sch[k][c]) begin
          sum += k - tin;
          n++;
          tin = -1;
        end
        if (n == 4) fin = k;
      end
      if (fin >= 0) begin
        et[c]   = CntW'(sum / 4);
        etmo[c] = 1'b0;
        if (fin + 2 > last) last = fin + 2;
      end else begin
        et[c]   = '1;
        etmo[c] = 1'b1;
        alldone = 1'b0;
      end
    end
    drain = (alldone && last + 1 < int'(Tmo)) ? last + 1 : int'(Tmo);
  endtask

  task automatic run_start();
    in_evt = '0; out_evt = '0; res_ready = 1'b0; fin_test = 1'b0;
    repeat (3) tick();
    chk("idle_busy", busy, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_in_measure", res_valid, 0);
  endtask

  task automatic measure(input int drain, output bit ok);
    int seen_at;
    seen_at = -1;
    for (int k = 0; k < int'(Tmo) + 20 && seen_at < 0; k++) begin
      in_evt  = in_sch[k];
      out_evt = out_sch[k];
      tick();
      if (res_valid) seen_at = k + 1;
    end
    in_evt  = '0;
    out_evt = '0;
    chk("drain_edge", seen_at, drain);
    ok = (seen_at >= 0);
  endtask

  task automatic drain_all(input vec_t v);
    for (int c = 0; c < NCh; c++) begin
      for (int h = 0; h <= int'(v.hold[c]); h++) begin
        res_ready = (h == int'(v.hold[c]));
        chk("res_valid", res_valid, 1);
        chk("res_ch", res_ch, c);
        chk("res_time", res_time, v.exp_time[c]);
        chk("res_tmo", res_tmo, v.exp_tmo[c]);
        chk("done_early", done, 0);
        tick();
      end
    end
    res_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 1);
    chk("valid_after_last", res_valid, 0);
    tick();
    chk("done_width", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [NCh-1:0][CntW-1:0] et;
    logic [NCh-1:0]           etmo;
    int                       dr;
    bit                       ok;
    build(v);
    model(et, etmo, dr);
    run_start();
    measure(dr, ok);
    if (ok) drain_all(v);
    else begin
      fin_test = 1'b1;
      tick();
      fin_test = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dd [4];
    bit ok;
    logic [NCh-1:0][CntW-1:0] et;
    logic [NCh-1:0]           etmo;
    int                       dr;
    dd = '{10, 12, 14, 16};
    rst_n = 1'b0; start = 1'b0; fin_test = 1'b0; res_ready = 1'b0;
    in_evt = '0; out_evt = '0;

    // Directed table entries.
    for (int i = 0; i < 3; i++) begin
      vecs[i].no_out = '0;
      vecs[i].hold   = '0;
      vecs[i].exp_tmo = '0;
      for (int c = 0; c < NCh; c++) begin
        vecs[i].exp_time[c] = CntW'(13);
        for (int p = 0; p < 4; p++) vecs[i].dly[c][p] = 8'(dd[p]);
      end
    end
    vecs[0].hold[1] = 4'd7;
    for (int c = 0; c < NCh; c++) begin
      vecs[1].exp_time[c] = (c == 0) ? CntW'(0) : CntW'(5);
      for (int p = 0; p < 4; p++) vecs[1].dly[c][p] = (c == 0) ? 8'd0 : 8'd5;
    end
    vecs[1].hold[0] = 4'd1;
    vecs[1].hold[2] = 4'd2;
    vecs[2].no_out      = 4'b0100;
    vecs[2].exp_time[2] = 16'hFFFF;
    vecs[2].exp_tmo     = 4'b0100;
    vecs[2].hold[3]     = 4'd3;

    // Random table entries, expectations from the reference model.
    for (int i = 3; i < NV; i++) begin
      for (int c = 0; c < NCh; c++) begin
        vecs[i].hold[c] = 4'($urandom_range(0, 3));
        for (int p = 0; p < 4; p++) vecs[i].dly[c][p] = 8'($urandom_range(0, 40));
      end
      vecs[i].no_out = ($urandom_range(0, 3) == 0) ? NCh'(1 << $urandom_range(0, NCh - 1)) : '0;
      build(vecs[i]);
      model(et, etmo, dr);
      vecs[i].exp_time = et;
      vecs[i].exp_tmo  = etmo;
    end

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_tmo", res_tmo, 0);
    chk("rst_ch", res_ch, 0);
    chk("rst_time", res_time, 0);
    #3 rst_n = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // fin_test mid-MEASURE.
    build(vecs[0]);
    run_start();
    for (int k = 0; k < 20; k++) begin
      in_evt = in_sch[k]; out_evt = out_sch[k];
      tick();
    end
    fin_test = 1'b1;
    tick();
    fin_test = 1'b0; in_evt = '0; out_evt = '0;
    chk("fin_meas_busy", busy, 0);
    chk("fin_meas_valid", res_valid, 0);
    chk("fin_meas_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fin_meas_nodone", done, 0);
    end

    // fin_test mid-DRAIN after the ch0 handshake.
    model(et, etmo, dr);
    run_start();
    measure(dr, ok);
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("drain_ch1", res_ch, 1);
    fin_test = 1'b1;
    tick();
    fin_test = 1'b0;
    chk("fin_drain_busy", busy, 0);
    chk("fin_drain_valid", res_valid, 0);
    chk("fin_drain_done", done, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("fin_drain_nodone", done, 0);
    end

    // fin_test wins over start.
    start = 1'b1; fin_test = 1'b1;
    tick();
    start = 1'b0; fin_test = 1'b0;
    chk("fin_over_start", busy, 0);

    run_vec(vecs[0]);

    // Async reset mid-COUNT.
    build(vecs[0]);
    run_start();
    for (int k = 0; k < 8; k++) begin
      in_evt = in_sch[k]; out_evt = out_sch[k];
      tick();
    end
    in_evt = '0; out_evt = '0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", res_valid, 0);
    chk("arst_done", done, 0);
    chk("arst_tmo", res_tmo, 0);
    chk("arst_ch", res_ch, 0);
    chk("arst_time", res_time, 0);
    start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("arst_start_ignored", busy, 0);
    end
    start = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    run_vec(vecs[0]);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
